// File: rtl/id_ctrl_stage.sv
// ID stage: full-instruction control decode registered behind valid/ready, load-use bubbles, flush, stall counter.
// Latency 1 cycle; holds its output under out_ready=0; SCPU_RV32M_EN adds the MUL/DIV R-type class (aluop 4'b1000).
module id_ctrl_stage #(
  parameter int XLEN  = 32,
`ifdef SCPU_RV32M_EN
  parameter int ALUOP_W = 4,
`else
  parameter int ALUOP_W = 3,
`endif
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_branch,
  output logic               out_mem_read,
  output logic               out_mem2reg,
  output logic               out_mem_write,
  output logic               out_alu_src,
  output logic               out_reg_write,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       unused_funct3;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];
  assign unused_funct3 = ^in_instr[14:12];

  logic               d_branch, d_mem_read, d_mem2reg, d_mem_write, d_alu_src, d_reg_write;
  logic               d_illegal, rs1_used, rs2_used;
  logic [ALUOP_W-1:0] d_aluop;

  always_comb begin
    d_branch    = 1'b0;
    d_mem_read  = 1'b0;
    d_mem2reg   = 1'b0;
    d_mem_write = 1'b0;
    d_alu_src   = 1'b0;
    d_reg_write = 1'b0;
    d_aluop     = '0;
    d_illegal   = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    case (opcode)
      OP_R: begin
`ifdef SCPU_RV32M_EN
        d_reg_write = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        d_aluop     = (funct7 == F7_MULDIV) ? ALUOP_W'(4'b1000) : ALUOP_W'(3'b010);
`else
        if (funct7 == F7_MULDIV) begin
          d_illegal = 1'b1;
        end else begin
          d_reg_write = 1'b1;
          rs1_used    = 1'b1;
          rs2_used    = 1'b1;
          d_aluop     = ALUOP_W'(3'b010);
        end
`endif
      end
      OP_LUI: begin
        d_aluop = ALUOP_W'(3'b100); d_alu_src = 1'b1; d_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        d_aluop = ALUOP_W'(3'b101); d_alu_src = 1'b1; d_reg_write = 1'b1;
      end
      OP_LD: begin
        d_mem_read = 1'b1; d_mem2reg = 1'b1; d_alu_src = 1'b1; d_reg_write = 1'b1;
        rs1_used = 1'b1;
      end
      OP_I: begin
        d_aluop = ALUOP_W'(3'b011); d_alu_src = 1'b1; d_reg_write = 1'b1;
        rs1_used = 1'b1;
      end
      OP_S: begin
        d_mem_write = 1'b1; d_alu_src = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_SB: begin
        d_branch = 1'b1; d_aluop = ALUOP_W'(3'b001);
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_JALR: begin
        d_branch = 1'b1; d_aluop = ALUOP_W'(3'b110); d_reg_write = 1'b1;
        rs1_used = 1'b1;
      end
      OP_JAL: begin
        d_branch = 1'b1; d_aluop = ALUOP_W'(3'b111); d_reg_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Tracks a load that has left this stage into EX, for the load-use check.
  logic       ex_ld_vld;
  logic [4:0] ex_ld_rd;
  logic       hazard, capture;

  assign hazard   = ex_ld_vld & in_valid &
                    ((rs1_used & (rs1 == ex_ld_rd)) | (rs2_used & (rs2 == ex_ld_rd)));
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_branch    <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem2reg   <= 1'b0;
      out_mem_write <= 1'b0;
      out_alu_src   <= 1'b0;
      out_reg_write <= 1'b0;
      out_aluop     <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_pc        <= '0;
      out_illegal   <= 1'b0;
      stall_cnt     <= '0;
      ex_ld_vld     <= 1'b0;
      ex_ld_rd      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ex_ld_vld <= 1'b0;
    end else begin
      if (out_ready) begin
        ex_ld_vld <= out_valid & out_mem_read & (out_rd != 5'd0);
        ex_ld_rd  <= out_rd;
      end
      if (capture) begin
        out_valid     <= 1'b1;
        out_branch    <= d_branch;
        out_mem_read  <= d_mem_read;
        out_mem2reg   <= d_mem2reg;
        out_mem_write <= d_mem_write;
        out_alu_src   <= d_alu_src;
        out_reg_write <= d_reg_write;
        out_aluop     <= d_aluop;
        out_rs1       <= rs1;
        out_rs2       <= rs2;
        out_rd        <= rd;
        out_pc        <= in_pc;
        out_illegal   <= d_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Randomized and directed bench for id_ctrl_stage against a table-driven stage-occupancy model.
module tb_id_ctrl_stage;

`ifdef SCPU_RV32M_EN
  localparam int AW = 4;
  localparam bit M_EN = 1'b1;
`else
  localparam int AW = 3;
  localparam bit M_EN = 1'b0;
`endif
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_instr = '0, in_pc = '0;
  logic          in_ready, out_valid;
  logic          out_branch, out_mem_read, out_mem2reg, out_mem_write, out_alu_src, out_reg_write;
  logic [AW-1:0] out_aluop;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [31:0]   out_pc;
  logic          out_illegal;
  logic [CW-1:0] stall_cnt;

  id_ctrl_stage #(.XLEN(32), .ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem2reg(out_mem2reg),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_aluop(out_aluop), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic br, mr, m2r, mw, asrc, rw, ill, u1, u2;
    logic [3:0] aop;
  } dec_t;

  typedef struct packed {
    logic br, mr, m2r, mw, asrc, rw, ill;
    logic [3:0] aop;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] pc;
  } bun_t;

  // Reference decode: rows transcribed as {branch,mem_read,mem2reg,aluop,mem_write,alu_src,reg_write}.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [8:0] row;
    logic [6:0] op;
    op = ins[6:0];
    d = '0;
    row = '0;
    case (op)
      7'b0110011: row = 9'b0_0_0_010_0_0_1;
      7'b0110111: row = 9'b0_0_0_100_0_1_1;
      7'b0010111: row = 9'b0_0_0_101_0_1_1;
      7'b0000011: row = 9'b0_1_1_000_0_1_1;
      7'b0010011: row = 9'b0_0_0_011_0_1_1;
      7'b0100011: row = 9'b0_0_0_000_1_1_0;
      7'b1100011: row = 9'b1_0_0_001_0_0_0;
      7'b1100111: row = 9'b1_0_0_110_0_0_1;
      7'b1101111: row = 9'b1_0_0_111_0_0_1;
      default:    d.ill = 1'b1;
    endcase
    if (op == 7'b0110011 && ins[31:25] == 7'b0000001 && !M_EN) begin
      row = '0;
      d.ill = 1'b1;
    end
    d.br = row[8]; d.mr = row[7]; d.m2r = row[6]; d.aop = {1'b0, row[5:3]};
    d.mw = row[2]; d.asrc = row[1]; d.rw = row[0];
    if (op == 7'b0110011 && ins[31:25] == 7'b0000001 && M_EN) d.aop = 4'b1000;
    d.u1 = !d.ill && (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111});
    d.u2 = !d.ill && (op inside {7'b0110011, 7'b0100011, 7'b1100011});
    return d;
  endfunction

  // Model: what occupies ID/EX, whether EX holds a load to a nonzero rd, and the stall count.
  logic       m_ov;
  bun_t       m_b;
  logic       m_ldv;
  logic [4:0] m_ldrd;
  int         m_cnt;

  function automatic logic [25:0] dut_ctrl();
    return {out_branch, out_mem_read, out_mem2reg, out_mem_write, out_alu_src, out_reg_write,
            out_illegal, 4'(out_aluop), out_rs1, out_rs2, out_rd};
  endfunction

  task automatic model_clear();
    m_ov = 1'b0; m_b = '0; m_ldv = 1'b0; m_ldrd = '0; m_cnt = 0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ctrl", dut_ctrl(), 0);
    chk("rst_pc", out_pc, 0);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic ordy);
    dec_t d;
    logic hz, rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_ov) begin
      chk("bundle", dut_ctrl(), {m_b.br, m_b.mr, m_b.m2r, m_b.mw, m_b.asrc, m_b.rw, m_b.ill,
                                 m_b.aop, m_b.rs1, m_b.rs2, m_b.rd});
      chk("out_pc", out_pc, m_b.pc);
    end
    d = ref_decode(ins);
    hz = m_ldv && v && ((d.u1 && ins[19:15] == m_ldrd) || (d.u2 && ins[24:20] == m_ldrd));
    rdy = !fl && !hz && (!m_ov || ordy);
    chk("in_ready", in_ready, rdy);
    if (fl) begin
      m_ov = 1'b0;
      m_ldv = 1'b0;
    end else begin
      if (ordy) begin
        m_ldv = m_ov && m_b.mr && (m_b.rd != 0);
        m_ldrd = m_b.rd;
      end
      if (v && rdy) begin
        m_b = {d.br, d.mr, d.m2r, d.mw, d.asrc, d.rw, d.ill, d.aop,
               ins[19:15], ins[24:20], ins[11:7], pc};
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (hz) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op, f7;
    case ($urandom_range(0, 10))
      0, 10:   op = 7'b0110011;
      1:       op = 7'b0110111;
      2:       op = 7'b0010111;
      3:       op = 7'b0000011;
      4:       op = 7'b0010011;
      5:       op = 7'b0100011;
      6:       op = 7'b1100011;
      7:       op = 7'b1100111;
      8:       op = 7'b1101111;
      default: op = 7'($urandom);
    endcase
    f7 = ($urandom_range(0, 2) == 0) ? 7'h01 : (($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20);
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] I_ADD   = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADDI  = 32'h00100393;  // addi x7,x0,1
  localparam logic [31:0] I_USE5  = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] I_USE0  = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] I_JAL   = 32'h000000EF;  // jal x1,0
  localparam logic [31:0] I_MUL   = 32'h022081B3;  // mul x3,x1,x2
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  initial begin
    do_reset();

    // Single ADD, one-cycle latency.
    step(1, I_ADD, 32'h100, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("add_vld", out_valid, 1'b1);
    chk("add_aluop", 4'(out_aluop), 4'b0010);
    chk("add_rw", out_reg_write, 1'b1);
    chk("add_rs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
    chk("add_ill", out_illegal, 1'b0);

    // Load-use: dependent ADD meets the load once it is in EX, costing one bubble.
    do_reset();
    step(1, I_LW5, 32'h10, 0, 1);
    step(1, I_ADDI, 32'h14, 0, 1);
    step(1, I_USE5, 32'h18, 0, 1);
    chk("ldu_stall", in_ready, 1'b0);
    step(1, I_USE5, 32'h18, 0, 1);
    chk("ldu_bubble", out_valid, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("ldu_emit", {out_valid, out_rd}, {1'b1, 5'd6});
    chk("ldu_cnt", stall_cnt, 1);

    // Back-to-back load then use, left to the model.
    step(1, I_LW5, 32'h20, 0, 1);
    step(1, I_USE5, 32'h24, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Load to x0 never stalls.
    do_reset();
    step(1, I_LW0, 32'h30, 0, 1);
    step(1, I_ADDI, 32'h34, 0, 1);
    step(1, I_USE0, 32'h38, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("x0_cnt", stall_cnt, 0);

    // Backpressure holds JAL for three cycles.
    do_reset();
    step(1, I_JAL, 32'h200, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, I_ADD, 32'h204, 0, 0);
      chk("hold_rdy", in_ready, 1'b0);
      chk("hold_pc", out_pc, 32'h200);
    end
    step(1, I_ADD, 32'h204, 0, 1);
    chk("rel_rdy", in_ready, 1'b1);
    step(0, 0, 0, 0, 1);
    chk("rel_pc", out_pc, 32'h204);

    // Flush with a bundle pending and a hazard active.
    do_reset();
    step(1, I_LW5, 32'h40, 0, 1);
    step(1, I_ADDI, 32'h44, 0, 1);
    step(1, I_USE5, 32'h48, 1, 1);
    step(1, I_USE5, 32'h48, 0, 1);
    chk("fl_vld", out_valid, 1'b0);
    chk("fl_rdy", in_ready, 1'b1);
    chk("fl_cnt", stall_cnt, 0);
    step(0, 0, 0, 0, 1);
    chk("fl_emit", {out_valid, out_pc}, {1'b1, 32'h48});

    // Illegal opcode and MUL.
    do_reset();
    step(1, I_BAD, 32'h50, 0, 1);
    step(1, I_MUL, 32'h54, 0, 1);
    chk("bad_ill", {out_valid, out_illegal}, 2'b11);
    chk("bad_ctrl", dut_ctrl() >> 15, 11'b000000_1_0000);
    step(0, 0, 0, 0, 1);
    chk("mul_ill", out_illegal, M_EN ? 1'b0 : 1'b1);
    chk("mul_aluop", 4'(out_aluop), M_EN ? 4'b1000 : 4'b0000);

    // Persistent hazard under backpressure drives the counter into saturation.
    do_reset();
    step(1, I_LW5, 32'h60, 0, 1);
    step(1, I_ADDI, 32'h64, 0, 1);
    for (int k = 0; k < 10; k++) step(1, I_USE5, 32'h68, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sat_cnt", stall_cnt, CMAX);

    // Random traffic with one asynchronous reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
